// File: rtl/regfile_pkg.sv
// Shared register-file definitions: widths, write-back requester ids
// and the write-stage bundle.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;
  localparam int WB_MDU  = 2;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
    logic [1:0]            id;
  } wb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant searched from
// rr_ptr upward, plus the pointer value to load after a grant.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any,
  output logic [PTR_W-1:0] next_ptr
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!any && req_valid[idx]) begin
        any            = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    next_ptr = rr_ptr;
    if (any) begin
      if (int'(grant_idx) == N - 1)
        next_ptr = '0;
      else
        next_ptr = grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port plus the
// per-register pending scoreboard used by decode for RAW stalls.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_reg,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  output logic [1:0]                grant_id,
  output logic [NUM_REGS-1:0]       pending
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    next_ptr;
  logic [PTR_W-1:0]    g_idx;
  logic                g_any;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_data;
  logic [NUM_REGS-1:0] pend_n;
  wb_t                 wb_q;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (req_ready),
    .grant_idx (g_idx),
    .any       (g_any),
    .next_ptr  (next_ptr)
  );

  assign g_addr = req_addr[int'(g_idx)*ADDR_W +: ADDR_W];
  assign g_data = req_data[int'(g_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= PTR_W'(WB_ALU);
    end else begin
      rr_ptr <= next_ptr;
    end
  end

  // $0 writes are handshaken but never enabled at the port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else if (g_any) begin
      wb_q.we   <= (g_addr != '0);
      wb_q.addr <= g_addr;
      wb_q.data <= g_data;
      wb_q.id   <= 2'(g_idx);
    end else begin
      wb_q.we   <= 1'b0;
    end
  end

  assign RegWrite   = wb_q.we;
  assign write_reg  = wb_q.addr;
  assign write_data = wb_q.data;
  assign grant_id   = wb_q.id;

  // set after clear: a fresh issue to the same reg stays pending
  always_comb begin
    pend_n = pending;
    if (wb_q.we)
      pend_n[wb_q.addr] = 1'b0;
    if (issue_valid && issue_reg != '0)
      pend_n[issue_reg] = 1'b1;
    pend_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pend_n;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: spec-level model checked every
// cycle plus directed literal checks of each scenario.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [1:0]  grant_id;
  logic [31:0] pending;

  int total = 0;
  int bad   = 0;

  // model state
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  logic [1:0]  m_gid;
  logic [31:0] m_pend;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .RegWrite    (RegWrite),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .grant_id    (grant_id),
    .pending     (pending)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // first valid requester at or after ptr, wrapping; -1 if none
  function automatic int winner(input logic [2:0] v, input int ptr);
    int order[3];
    order[0] = ptr;
    order[1] = (ptr + 1) % 3;
    order[2] = (ptr + 2) % 3;
    foreach (order[j])
      if (v[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic logic [2:0] onehot(input int w);
    logic [2:0] r;
    r = 3'b000;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] pend_next(
    input logic [31:0] p, input logic we, input logic [4:0] wr,
    input logic iv, input logic [4:0] ir);
    logic [31:0] n;
    n = p;
    if (we) n[wr] = 1'b0;
    if (iv && ir != 5'd0) n[ir] = 1'b1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr   <= 0;
      m_we    <= 1'b0;
      m_wreg  <= '0;
      m_wdata <= '0;
      m_gid   <= '0;
      m_pend  <= '0;
    end else begin
      m_pend <= pend_next(m_pend, m_we, m_wreg, issue_valid,
                          issue_reg);
      if (winner(req_valid, m_ptr) >= 0) begin
        m_ptr   <= (winner(req_valid, m_ptr) + 1) % 3;
        m_we    <= req_addr[winner(req_valid, m_ptr)*5 +: 5] != 5'd0;
        m_wreg  <= req_addr[winner(req_valid, m_ptr)*5 +: 5];
        m_wdata <= req_data[winner(req_valid, m_ptr)*32 +: 32];
        m_gid   <= 2'(winner(req_valid, m_ptr));
      end else begin
        m_we <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_ready", {61'd0, req_ready},
        {61'd0, onehot(winner(req_valid, m_ptr))});
    chk("model_we", {63'd0, RegWrite}, {63'd0, m_we});
    chk("model_wreg", {59'd0, write_reg}, {59'd0, m_wreg});
    chk("model_wdata", {32'd0, write_data}, {32'd0, m_wdata});
    chk("model_gid", {62'd0, grant_id}, {62'd0, m_gid});
    chk("model_pend", {32'd0, pending}, {32'd0, m_pend});
  end

  task automatic set_req(input int i, input logic v,
                         input logic [4:0] a, input logic [31:0] d);
    req_valid[i]        = v;
    req_addr[i*5 +: 5]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_reg   = '0;
    step();
    step();
    chk("rst_we", {63'd0, RegWrite}, 64'd0);
    chk("rst_wreg", {59'd0, write_reg}, 64'd0);
    chk("rst_wdata", {32'd0, write_data}, 64'd0);
    chk("rst_gid", {62'd0, grant_id}, 64'd0);
    chk("rst_pend", {32'd0, pending}, 64'd0);
    rst_n = 1'b1;

    // ALU alone
    step();
    set_req(0, 1'b1, 5'd8, 32'h0000_00AA);
    #1;
    chk("alu_ready", {61'd0, req_ready}, 64'b001);
    step();
    set_req(0, 1'b0, 5'd0, 32'd0);
    chk("alu_we", {63'd0, RegWrite}, 64'd1);
    chk("alu_wreg", {59'd0, write_reg}, 64'd8);
    chk("alu_wdata", {32'd0, write_data}, 64'hAA);
    chk("alu_gid", {62'd0, grant_id}, 64'd0);

    // all three continuously valid
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    set_req(2, 1'b1, 5'd3, 32'h33);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rr_ready", {61'd0, req_ready}, {61'd0, onehot(i)});
      step();
      chk("rr_we", {63'd0, RegWrite}, 64'd1);
      chk("rr_wreg", {59'd0, write_reg}, 64'(i + 1));
    end
    chk("rr_wdata", {32'd0, write_data}, 64'h33);
    req_valid = '0;

    // load writes $0
    step();
    set_req(1, 1'b1, 5'd0, 32'hDEAD_BEEF);
    #1;
    chk("z_ready", {61'd0, req_ready}, 64'b010);
    step();
    set_req(1, 1'b0, 5'd0, 32'd0);
    chk("z_we", {63'd0, RegWrite}, 64'd0);
    chk("z_gid", {62'd0, grant_id}, 64'd1);
    chk("z_pend0", {63'd0, pending[0]}, 64'd0);

    // issue r9, ALU writes r9 two cycles later
    issue_valid = 1'b1;
    issue_reg   = 5'd9;
    step();
    issue_valid = 1'b0;
    chk("raw_set", {63'd0, pending[9]}, 64'd1);
    step();
    set_req(0, 1'b1, 5'd9, 32'h99);
    chk("raw_hold", {63'd0, pending[9]}, 64'd1);
    step();
    set_req(0, 1'b0, 5'd0, 32'd0);
    chk("raw_we", {63'd0, RegWrite}, 64'd1);
    chk("raw_still", {63'd0, pending[9]}, 64'd1);
    step();
    chk("raw_clr", {63'd0, pending[9]}, 64'd0);

    // same-edge set and clear of r5
    set_req(0, 1'b1, 5'd5, 32'h55);
    step();
    set_req(0, 1'b0, 5'd0, 32'd0);
    issue_valid = 1'b1;
    issue_reg   = 5'd5;
    chk("same_we", {63'd0, RegWrite}, 64'd1);
    chk("same_wreg", {59'd0, write_reg}, 64'd5);
    step();
    issue_valid = 1'b0;
    chk("same_pend", {63'd0, pending[5]}, 64'd1);

    // async reset mid-write
    do_reset();
    issue_valid = 1'b1;
    issue_reg   = 5'd8;
    step();
    issue_reg   = 5'd9;
    step();
    issue_valid = 1'b0;
    set_req(1, 1'b1, 5'd7, 32'h77);
    step();
    set_req(1, 1'b0, 5'd0, 32'd0);
    chk("ar_we", {63'd0, RegWrite}, 64'd1);
    chk("ar_pend", {32'd0, pending}, 64'h0000_0300);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_we0", {63'd0, RegWrite}, 64'd0);
    chk("ar_pend0", {32'd0, pending}, 64'd0);
    step();
    rst_n = 1'b1;
    req_valid = 3'b111;
    #1;
    chk("ar_first", {61'd0, req_ready}, 64'b001);
    step();
    req_valid = '0;
    chk("ar_gid", {62'd0, grant_id}, 64'd0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32 x 32-bit MIPS register file.
- Shares the register file's single write port (`RegWrite` / `write_reg` / `write_data`) between several result producers (ALU, load unit, multiply/divide unit) using round-robin arbitration and valid/ready handshakes.
- Keeps a per-register pending scoreboard so decode can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file write port.

## Interface

Parameters:
- `NUM_REQ`, 3: number of write-back requesters (id 0 = ALU, 1 = load, 2 = MDU).
- `DATA_W`, 32: write data width.
- `ADDR_W`, 5: register address width.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  requester i holds a result.
- `req_ready`  out  NUM_REQ  one-hot grant; the transfer happens when `req_valid[i] & req_ready[i]`.
- `req_addr`  in  NUM_REQ*ADDR_W  destination register, slice i = requester i.
- `req_data`  in  NUM_REQ*DATA_W  result data, slice i = requester i.
- `issue_valid`  in  1  decode issues an instruction that writes `issue_reg`.
- `issue_reg`  in  ADDR_W  destination being issued.
- `RegWrite`  out  1  register file write enable, registered.
- `write_reg`  out  ADDR_W  register file write address, registered.
- `write_data`  out  DATA_W  register file write data, registered.
- `grant_id`  out  2  id of the requester that drove the current write, registered.
- `pending`  out  32  scoreboard; bit r = 1 while a write to register r is outstanding.

## Operation

Arbitration:
- Round-robin, pointer `rr_ptr` in 0..NUM_REQ-1.
- Search order is `rr_ptr`, `rr_ptr+1`, … modulo NUM_REQ. The first requester with `req_valid` set wins.
- `req_ready` is combinational from `req_valid` and `rr_ptr`. At most one bit is set. All bits are 0 when no requester is valid.
- On a grant to requester g, `rr_ptr` becomes (g+1) mod NUM_REQ. With no grant, `rr_ptr` holds.

Write stage (registered):
- On a grant, capture `req_addr[g]`, `req_data[g]` and g into `write_reg`, `write_data` and `grant_id`.
- `RegWrite` is set to 1 only if `req_addr[g]` != 0.
- Writes to $0 are accepted (ready asserted, requester released) but never reach the register file.
- With no grant, `RegWrite` = 0. `write_reg`, `write_data` and `grant_id` hold their last values.

Scoreboard:
- On the clock edge where `issue_valid` = 1 and `issue_reg` != 0: set `pending[issue_reg]`.
- On the clock edge where `RegWrite` = 1: clear `pending[write_reg]`.
- If set and clear target the same register on the same edge, set wins (a newer writer is outstanding).
- `pending[0]` is always 0.
- Requesters must not reorder writes to the same register; the arbiter does not check this.

## Timing

- Reset (asynchronous assertion, synchronous-safe release): `RegWrite` = 0, `write_reg` = 0, `write_data` = 0, `grant_id` = 0, `rr_ptr` = 0, `pending` = 0.
- Latency: a request accepted in cycle N appears as `RegWrite` = 1 in cycle N+1. The register file commits on the edge ending cycle N+1.
- Throughput: one write per cycle with no bubbles. Back-to-back grants are allowed.
- Handshake rules:
  - Once asserted, a requester keeps `req_valid`, `req_addr` and `req_data` stable until accepted.
  - `req_ready` may toggle without `req_valid` changing.
- Simultaneous requests: at most one is granted per cycle. The others wait.
  - With all three requesters continuously valid, the grant sequence is 0,1,2,0,…
  - Worst-case wait is NUM_REQ-1 cycles.
- Reset mid-operation: any captured but not-yet-written entry is dropped, `RegWrite` is forced to 0 immediately, and the scoreboard is cleared. No partial write occurs.
- `pending` is registered. Decode observes a newly issued destination as pending from cycle N+1 after issue.

## Structure

- Shared package `regfile_pkg`:
  - `REG_ADDR_W` = 5, `REG_DATA_W` = 32, `NUM_REGS` = 32.
  - Requester id constants `WB_ALU` = 0, `WB_LOAD` = 1, `WB_MDU` = 2.
- Sub-module `rr_arbiter`: combinational one-hot grant from `req_valid` and `rr_ptr`, plus the next-pointer value. It is reusable for the memory port.
- The top level holds the write-stage registers, the `rr_ptr` register and the scoreboard.

## Test plan

- Reset release, then ALU only: `req_valid` = 001, addr 8, data 0x0000_00AA -> `req_ready` = 001 in the same cycle; next cycle `RegWrite` = 1, `write_reg` = 8, `write_data` = 0xAA, `grant_id` = 0.
- All three valid continuously with addrs 1/2/3 and data 0x11/0x22/0x33 -> grants 001, 010, 100 on consecutive cycles; `write_reg` sequence 1,2,3; no idle cycle.
- Load writes $0 with data 0xDEAD_BEEF -> `req_ready[1]` = 1; next cycle `RegWrite` = 0; `pending[0]` stays 0.
- Issue reg 9, then the ALU writes reg 9 two cycles later -> `pending[9]` is 1 from the cycle after issue and returns to 0 the cycle after `RegWrite` = 1.
- Same edge: `RegWrite` = 1 to reg 5 while `issue_valid` = 1 with `issue_reg` = 5 -> `pending[5]` stays 1.
- `rst_n` pulled low asynchronously while `RegWrite` = 1 and `pending` = 0x0000_0300 -> `RegWrite` = 0 and `pending` = 0 before the next clock edge; after release, the first grant goes to requester 0.
